// File: rtl/riscv_pkg.sv
// Shared RV32I front-end types and constants.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_pkt_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// In-order FIFO of fetched packets; flush empties it and beats a same-cycle push.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  fetch_pkt_t    pkt_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output fetch_pkt_t    head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    fetch_pkt_t    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push && !flush_i) mem_q[wr_q] <= pkt_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch front end: PC, credit-limited imem requests, packet queue to decode.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tag_q, tag_d;      // PC of the next response that will be kept
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    logic [CW-1:0] q_count;
    logic          q_full, q_empty;
    fetch_pkt_t    q_head, q_in;

    logic [CW:0]   credits_used;
    logic [31:0]   redir_pc;
    logic          accept, push, pop;

    assign redir_pc     = word_align(redirect_pc);
    assign credits_used = {1'b0, inflight_q} + {1'b0, q_count};

    assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle belongs to the old stream whatever drop_q says.
    assign push = imem_rsp_valid && !redirect_valid && (drop_q == '0);

    assign dec_valid    = !reset && !q_empty;
    assign pop          = dec_valid && dec_ready;
    assign dec_instr    = dec_valid ? q_head.instr : '0;
    assign dec_pc       = dec_valid ? q_head.pc : '0;
    assign dec_pc_plus4 = dec_valid ? q_head.pc + 32'd4 : '0;

    assign q_in.instr = imem_rsp_data;
    assign q_in.pc    = tag_q;

    always_comb begin
        pc_d       = pc_q;
        tag_d      = tag_q;
        drop_d     = drop_q;
        inflight_d = inflight_q + CW'(accept) - CW'(imem_rsp_valid);
        if (redirect_valid) begin
            pc_d   = redir_pc;
            tag_d  = redir_pc;
            drop_d = inflight_q - CW'(imem_rsp_valid);
        end else begin
            if (accept) pc_d = pc_q + 32'd4;
            if (push)   tag_d = tag_q + 32'd4;
            if (imem_rsp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= word_align(RESET_PC);
            tag_q      <= word_align(RESET_PC);
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && q_full));
            assert (!(imem_rsp_valid && inflight_q == '0));
        end
    end

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pkt_i   (q_in),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .head_o  (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

endmodule
